// File: rtl/mux_skid_kx1_if.sv
// Handshake bundle for mux_skid_kx1: K flattened N-bit sources in, one selected
// word out through a valid/ready skid buffer.
interface mux_skid_kx1_if #(
  parameter int N = 32,
  parameter int K = 4
);
  localparam int SEL_W = (K > 1) ? $clog2(K) : 1;

  logic [K*N-1:0]   in_data;
  logic [SEL_W-1:0] sel_idx;
  logic [K-1:0]     sel_oh;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     out_data;
  logic [SEL_W-1:0] out_src;
  logic             out_valid;
  logic             out_ready;
  logic             flush;
  logic             sel_err;
  logic [1:0]       occupancy;

  modport master (
    output in_data, sel_idx, sel_oh, in_valid, out_ready, flush,
    input  in_ready, out_data, out_src, out_valid, sel_err, occupancy
  );

  modport slave (
    input  in_data, sel_idx, sel_oh, in_valid, out_ready, flush,
    output in_ready, out_data, out_src, out_valid, sel_err, occupancy
  );
endinterface

// File: rtl/mux_skid_kx1.sv
// K:1 N-bit selector (binary index or one-hot priority) feeding a 2-entry
// valid/ready skid buffer; in_ready depends only on buffer state.
module mux_skid_kx1 #(
  parameter int N    = 32,
  parameter int K    = 4,
  parameter int MODE = 0
) (
  input  logic          clk,
  input  logic          rst,
  mux_skid_kx1_if.slave bus
);
  localparam int SEL_W = (K > 1) ? $clog2(K) : 1;
  localparam int KP    = 1 << SEL_W;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Source table padded to a power of two so any index value stays in range.
  logic [N-1:0] src_arr [KP];

  genvar gi;
  generate
    for (gi = 0; gi < KP; gi++) begin : g_src
      if (gi < K) begin : g_real
        assign src_arr[gi] = bus.in_data[gi*N +: N];
      end else begin : g_pad
        assign src_arr[gi] = '0;
      end
    end
  endgenerate

  logic [SEL_W-1:0] pick_idx;
  logic             sel_ok;
  logic [N-1:0]     pick_data;

  generate
    if (MODE == 0) begin : g_bin
      localparam logic [SEL_W:0] K_LIM = (SEL_W+1)'(K);
      logic unused_oh;
      assign unused_oh = ^bus.sel_oh;
      assign sel_ok    = ({1'b0, bus.sel_idx} < K_LIM);
      assign pick_idx  = bus.sel_idx;
    end else begin : g_pri
      logic unused_idx;
      assign unused_idx = ^bus.sel_idx;
      assign sel_ok     = |bus.sel_oh;
      // Scan from the top so the lowest set request wins.
      always_comb begin
        pick_idx = '0;
        for (int i = K - 1; i >= 0; i--) begin
          if (bus.sel_oh[i]) pick_idx = SEL_W'(i);
        end
      end
    end
  endgenerate

  assign pick_data = src_arr[pick_idx];

  logic [1:0]       state_reg, state_next;
  logic [N-1:0]     head_data_reg, head_data_next;
  logic [SEL_W-1:0] head_src_reg, head_src_next;
  logic [N-1:0]     skid_data_reg, skid_data_next;
  logic [SEL_W-1:0] skid_src_reg, skid_src_next;
  logic             sel_err_reg, sel_err_next;

  logic not_full;
  logic accept;
  logic pop;

  assign not_full = (state_reg != ST_FULL);
  assign accept   = bus.in_valid & not_full & sel_ok;
  assign pop      = (state_reg != ST_EMPTY) & bus.out_ready;

  always_comb begin
    state_next     = state_reg;
    head_data_next = head_data_reg;
    head_src_next  = head_src_reg;
    skid_data_next = skid_data_reg;
    skid_src_next  = skid_src_reg;
    sel_err_next   = bus.in_valid & not_full & ~sel_ok & ~bus.flush;

    if (bus.flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            state_next     = ST_ONE;
            head_data_next = pick_data;
            head_src_next  = pick_idx;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            head_data_next = pick_data;
            head_src_next  = pick_idx;
          end else if (accept) begin
            state_next     = ST_FULL;
            skid_data_next = pick_data;
            skid_src_next  = pick_idx;
          end else if (pop) begin
            state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_next     = ST_ONE;
            head_data_next = skid_data_reg;
            head_src_next  = skid_src_reg;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_EMPTY;
      head_data_reg <= '0;
      head_src_reg  <= '0;
      skid_data_reg <= '0;
      skid_src_reg  <= '0;
      sel_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      head_data_reg <= head_data_next;
      head_src_reg  <= head_src_next;
      skid_data_reg <= skid_data_next;
      skid_src_reg  <= skid_src_next;
      sel_err_reg   <= sel_err_next;
    end
  end

  // rst gates in_ready directly so nothing is offered during reset.
  assign bus.in_ready  = not_full & ~rst;
  assign bus.out_valid = (state_reg != ST_EMPTY);
  assign bus.out_data  = head_data_reg;
  assign bus.out_src   = head_src_reg;
  assign bus.sel_err   = sel_err_reg;
  assign bus.occupancy = state_reg;
endmodule

// File: tb/tb_mux_skid_kx1.sv
// Runs three selectors (binary K=4, priority K=4, binary K=3) on shared stimulus
// against a per-instance queue model of the skid buffer.
module tb_mux_skid_kx1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]  srcv [4];
  logic [127:0] in_data;
  logic [1:0]   sel_idx;
  logic [3:0]   sel_oh;
  logic         in_valid, out_ready, flush;

  assign in_data = {srcv[3], srcv[2], srcv[1], srcv[0]};

  mux_skid_kx1_if #(.N(32), .K(4)) m_if ();
  mux_skid_kx1_if #(.N(32), .K(4)) o_if ();
  mux_skid_kx1_if #(.N(32), .K(3)) k_if ();

  assign m_if.in_data = in_data;        assign o_if.in_data = in_data;
  assign m_if.sel_idx = sel_idx;        assign o_if.sel_idx = sel_idx;
  assign m_if.sel_oh = sel_oh;          assign o_if.sel_oh = sel_oh;
  assign m_if.in_valid = in_valid;      assign o_if.in_valid = in_valid;
  assign m_if.out_ready = out_ready;    assign o_if.out_ready = out_ready;
  assign m_if.flush = flush;            assign o_if.flush = flush;
  assign k_if.in_data = in_data[95:0];
  assign k_if.sel_idx = sel_idx;
  assign k_if.sel_oh = sel_oh[2:0];
  assign k_if.in_valid = in_valid;
  assign k_if.out_ready = out_ready;
  assign k_if.flush = flush;

  mux_skid_kx1 #(.N(32), .K(4), .MODE(0)) u_bin (.clk(clk), .rst(rst), .bus(m_if));
  mux_skid_kx1 #(.N(32), .K(4), .MODE(1)) u_pri (.clk(clk), .rst(rst), .bus(o_if));
  mux_skid_kx1 #(.N(32), .K(3), .MODE(0)) u_k3  (.clk(clk), .rst(rst), .bus(k_if));

  int n_cmp = 0;
  int n_bad = 0;
  logic [33:0] sb [3][$];
  logic        err_next [3];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Before the edge: check head, then apply this cycle's handshake to the model.
  task automatic model_pre(input int d, input logic ok, input logic [1:0] idx,
                           input logic [1:0] o_src, input logic [31:0] o_data,
                           input logic o_valid);
    logic [33:0] e;
    int sz;
    bit acc, pop;
    sz = sb[d].size();
    chk($sformatf("d%0d_valid", d), o_valid, sz > 0);
    if (sz > 0) begin
      e = sb[d][0];
      chk($sformatf("d%0d_head_data", d), o_data, e[31:0]);
      chk($sformatf("d%0d_head_src", d), o_src, e[33:32]);
    end
    acc = in_valid && (sz < 2) && ok;
    pop = (sz > 0) && out_ready;
    err_next[d] = !flush && in_valid && (sz < 2) && !ok;
    if (flush) begin
      sb[d].delete();
      $display("flush d%0d", d);
    end else begin
      if (pop) begin
        e = sb[d].pop_front();
        $display("pop  d%0d src=%0d data=%08h", d, e[33:32], e[31:0]);
      end
      if (acc) begin
        sb[d].push_back({idx, srcv[idx]});
        $display("push d%0d src=%0d data=%08h", d, idx, srcv[idx]);
      end
    end
  endtask

  task automatic model_post(input int d, input logic [1:0] occ, input logic ov,
                            input logic ir, input logic se);
    int sz;
    sz = sb[d].size();
    chk($sformatf("d%0d_occupancy", d), occ, sz);
    chk($sformatf("d%0d_valid_post", d), ov, sz > 0);
    chk($sformatf("d%0d_in_ready", d), ir, sz < 2);
    chk($sformatf("d%0d_sel_err", d), se, err_next[d]);
  endtask

  task automatic step();
    logic [1:0] oh_i;
    if (sel_oh[0])      oh_i = 2'd0;
    else if (sel_oh[1]) oh_i = 2'd1;
    else if (sel_oh[2]) oh_i = 2'd2;
    else                oh_i = 2'd3;
    model_pre(0, 1'b1, sel_idx, m_if.out_src, m_if.out_data, m_if.out_valid);
    model_pre(1, |sel_oh, oh_i, o_if.out_src, o_if.out_data, o_if.out_valid);
    model_pre(2, sel_idx < 2'd3, sel_idx, k_if.out_src, k_if.out_data, k_if.out_valid);
    @(posedge clk);
    #1;
    model_post(0, m_if.occupancy, m_if.out_valid, m_if.in_ready, m_if.sel_err);
    model_post(1, o_if.occupancy, o_if.out_valid, o_if.in_ready, o_if.sel_err);
    model_post(2, k_if.occupancy, k_if.out_valid, k_if.in_ready, k_if.sel_err);
  endtask

  task automatic set_abcd();
    srcv[0] = 32'hA0; srcv[1] = 32'hB1; srcv[2] = 32'hC2; srcv[3] = 32'hD3;
  endtask

  task automatic clear_model();
    for (int d = 0; d < 3; d++) begin
      sb[d].delete();
      err_next[d] = 1'b0;
    end
  endtask

  initial begin
    in_valid = 0; out_ready = 0; flush = 0; sel_idx = 0; sel_oh = 0;
    set_abcd();
    clear_model();

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", m_if.out_valid, 1'b0);
    chk("rst_in_ready", m_if.in_ready, 1'b0);
    chk("rst_occupancy", m_if.occupancy, 2'd0);
    chk("rst_out_data", m_if.out_data, 32'h0);
    chk("rst_out_src", m_if.out_src, 2'd0);
    chk("rst_sel_err", m_if.sel_err, 1'b0);
    #2 rst = 1'b0;
    #1 chk("release_in_ready", m_if.in_ready, 1'b1);

    // First accept
    sel_idx = 2; sel_oh = 4'b0100; in_valid = 1;
    step();
    in_valid = 0;
    chk("first_valid", m_if.out_valid, 1'b1);
    chk("first_data", m_if.out_data, 32'hC2);
    chk("first_src", m_if.out_src, 2'd2);
    chk("first_occ", m_if.occupancy, 2'd1);
    out_ready = 1; step(); out_ready = 0;

    // Backpressure into the skid entry
    in_valid = 1; sel_idx = 1; sel_oh = 4'b0010; step();
    sel_idx = 3; sel_oh = 4'b1000; step();
    in_valid = 0;
    chk("skid_occ", m_if.occupancy, 2'd2);
    chk("skid_in_ready", m_if.in_ready, 1'b0);
    chk("skid_head", m_if.out_data, 32'hB1);
    step();
    out_ready = 1; step(); step(); out_ready = 0;
    chk("skid_drained", m_if.out_valid, 1'b0);

    // Streaming at full rate with fresh source words each cycle
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 4; j++) srcv[j] = $urandom;
      sel_idx = 2'(i % 4);
      sel_oh  = 4'(4'hF << (i % 4));
      step();
      chk("stream_occ", m_if.occupancy, 2'd1);
      chk("stream_in_ready", m_if.in_ready, 1'b1);
    end
    in_valid = 0; step(); out_ready = 0;
    set_abcd();

    // Priority mode and invalid one-hot
    sel_oh = 4'b1010; sel_idx = 0; in_valid = 1; step();
    chk("oh_src", o_if.out_src, 2'd1);
    chk("oh_data", o_if.out_data, 32'hB1);
    sel_oh = 4'b0000; step();
    in_valid = 0;
    chk("oh_err", o_if.sel_err, 1'b1);
    chk("oh_occ", o_if.occupancy, 2'd1);
    step();
    chk("oh_err_clear", o_if.sel_err, 1'b0);
    out_ready = 1; step(); step(); out_ready = 0;

    // Out-of-range index on K=3
    sel_idx = 3; in_valid = 1; step();
    in_valid = 0;
    chk("k3_err", k_if.sel_err, 1'b1);
    chk("k3_occ", k_if.occupancy, 2'd0);
    step();
    chk("k3_err_clear", k_if.sel_err, 1'b0);

    // Flush while FULL, racing accept, pop and an invalid offer
    in_valid = 1; sel_idx = 0; sel_oh = 4'b0001; step(); step();
    chk("fl_full", m_if.occupancy, 2'd2);
    flush = 1; out_ready = 1; sel_idx = 3; sel_oh = 4'b0000; step();
    flush = 0; in_valid = 0; out_ready = 0;
    chk("fl_occ", m_if.occupancy, 2'd0);
    chk("fl_valid", m_if.out_valid, 1'b0);
    chk("fl_in_ready", m_if.in_ready, 1'b1);
    chk("fl_k3_err", k_if.sel_err, 1'b0);
    chk("fl_oh_err", o_if.sel_err, 1'b0);

    // Asynchronous reset while FULL
    in_valid = 1; sel_idx = 1; sel_oh = 4'b0010; step(); step();
    in_valid = 0;
    chk("ar_full", m_if.occupancy, 2'd2);
    #3 rst = 1'b1;
    #1;
    chk("ar_out_valid", m_if.out_valid, 1'b0);
    chk("ar_in_ready", m_if.in_ready, 1'b0);
    chk("ar_occ", m_if.occupancy, 2'd0);
    chk("ar_out_data", m_if.out_data, 32'h0);
    clear_model();
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("ar_release_ready", m_if.in_ready, 1'b1);
    in_valid = 1; sel_idx = 3; sel_oh = 4'b1000; step();
    in_valid = 0; out_ready = 1; step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
